// File: rtl/rom_control.sv
// rom_control: constant 64-word microcode store with a registered output word.
module rom_control #(
  parameter int WIDTH_ADD  = 6,
  parameter int WIDTH_DATA = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH_ADD-1:0]  Addr,
  output logic [WIDTH_DATA-1:0] Data
);
  localparam int USED = 9;
  // Only the first nine words hold microcode; every other address reads zero.
  localparam logic [WIDTH_DATA-1:0] ROM [16] = '{
    WIDTH_DATA'(20'h00C44), WIDTH_DATA'(20'h0100A), WIDTH_DATA'(20'h00012),
    WIDTH_DATA'(20'h00080), WIDTH_DATA'(20'h03120), WIDTH_DATA'(20'h03280),
    WIDTH_DATA'(20'h22011), WIDTH_DATA'(20'h00013), WIDTH_DATA'(20'h03100),
    '0, '0, '0, '0, '0, '0, '0
  };
  logic [WIDTH_DATA-1:0] data_d, data_q;
  always_comb data_d = (Addr < WIDTH_ADD'(USED)) ? ROM[Addr[3:0]] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  assign Data = data_q;
endmodule

// File: tb/tb_rom_control.sv
// tb_rom_control: table vectors, directed reset/wrap/stability sequences and random sweep vs a reference table.
module tb_rom_control;
  logic clk = 1'b0, clk_en = 1'b0, rst;
  logic [5:0] Addr;
  logic [19:0] Data;
  int total = 0, bad = 0;

  rom_control dut (.clk(clk), .rst(rst), .Addr(Addr), .Data(Data));

  always #5 clk = clk_en ? ~clk : 1'b0;

  typedef struct { logic [5:0] addr; logic [19:0] exp; } vec_t;

  function automatic logic [19:0] rom_ref(input int a);
    case (a)
      0: return 20'h00C44;
      1: return 20'h0100A;
      2: return 20'h00012;
      3: return 20'h00080;
      4: return 20'h03120;
      5: return 20'h03280;
      6: return 20'h22011;
      7: return 20'h00013;
      8: return 20'h03100;
      default: return 20'h00000;
    endcase
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vecs[14];
    int rs_ref[9];
    logic [19:0] held;
    vecs = '{
      '{6'd0, 20'h00C44}, '{6'd1, 20'h0100A}, '{6'd2, 20'h00012}, '{6'd3, 20'h00080},
      '{6'd4, 20'h03120}, '{6'd5, 20'h03280}, '{6'd6, 20'h22011}, '{6'd7, 20'h00013},
      '{6'd8, 20'h03100}, '{6'd9, 20'h00000}, '{6'd15, 20'h00000}, '{6'd16, 20'h00000},
      '{6'd40, 20'h00000}, '{6'd63, 20'h00000}
    };
    rs_ref = '{2, 0, 0, 0, 1, 0, 0, 0, 0};

    rst = 1'b1; Addr = 6'd5;
    #3 check("reset_no_clock", Data, 20'h00000);
    #2 check("reset_held", Data, 20'h00000);
    #2 rst = 1'b0; clk_en = 1'b1;
    #1 check("release_no_edge", Data, 20'h00000);
    step();
    check("first_edge_after_reset", Data, 20'h03280);

    Addr = 6'd0;
    step();
    check("fetch_word", Data, 20'h00C44);
    check("fetch_resultsrc", {18'd0, Data[6:5]}, 20'd2);

    foreach (vecs[i]) begin
      Addr = vecs[i].addr;
      step();
      check($sformatf("vec_addr%0d", vecs[i].addr), Data, vecs[i].exp);
    end

    for (int a = 0; a < 64; a++) begin
      Addr = 6'(a);
      step();
      check($sformatf("sweep_%0d", a), Data, rom_ref(a));
      check($sformatf("sweep_rs_%0d", a), {18'd0, Data[6:5]}, 20'(a < 9 ? rs_ref[a] : 0));
    end

    Addr = 6'd63; step();
    check("wrap_63", Data, 20'h00000);
    Addr = 6'd0; step();
    check("wrap_0", Data, 20'h00C44);

    Addr = 6'd6; step();
    check("mid_reset_before", Data, 20'h22011);
    #1 rst = 1'b1;
    #1 check("mid_reset_async", Data, 20'h00000);
    Addr = 6'd8;
    step();
    check("reset_held_over_edge", Data, 20'h00000);
    rst = 1'b0;
    step();
    check("mid_reset_resume", Data, 20'h03100);

    Addr = 6'd4; step();
    held = Data;
    check("stab_loaded", held, 20'h03120);
    for (int k = 0; k < 4; k++) begin
      Addr = 6'($urandom_range(0, 63));
      #1 check("stab_between_edges", Data, held);
    end

    for (int n = 0; n < 300; n++) begin
      int a;
      a = $urandom_range(0, 63);
      if (n % 3 == 0) a = $urandom_range(0, 9);
      Addr = 6'(a);
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        #1 check("rand_async_reset", Data, 20'h00000);
        rst = 1'b0;
      end
      step();
      check($sformatf("rand_addr%0d", a), Data, rom_ref(a));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
